fpu_bus_if: RTL and testbench

FPU_BUS_IF -- requirements
Module: fpu_bus_if

---
 rtl/fpu_bus_if_pkg.sv | 39 +++
 rtl/fpu_bus_if_if.sv | 19 +
 rtl/fpu_bus_if.sv | 166 ++++++++++++++++
 tb/tb_fpu_bus_if.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_bus_if_pkg.sv
// Shared types and constants for the CPU-side register front end of the FPU.
// Holds the op set, the FSM states, the register map and the status bit positions.
package pa_fpu;

  typedef enum logic [2:0] {
    op_add  = 3'd0,
    op_sub  = 3'd1,
    op_mul  = 3'd2,
    op_div  = 3'd3,
    op_sqrt = 3'd4
  } e_fpu_op;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } e_bus_state;

  localparam logic [3:0] ADDR_A0     = 4'h0;
  localparam logic [3:0] ADDR_B0     = 4'h4;
  localparam logic [3:0] ADDR_RES0   = 4'h8;
  localparam logic [3:0] ADDR_CMD    = 4'hC;
  localparam logic [3:0] ADDR_STATUS = 4'hD;
  localparam logic [3:0] ADDR_IRQ_EN = 4'hE;
  localparam logic [3:0] ADDR_RSVD   = 4'hF;

  localparam int unsigned STS_RUNNING = 0;
  localparam int unsigned STS_DONE    = 1;
  localparam int unsigned STS_OVERRUN = 2;
  localparam int unsigned STS_TIMEOUT = 3;
  localparam int unsigned STS_ILLEGAL = 4;

  localparam logic [15:0] FPU_TIMEOUT_CYCLES = 16'd4096;

  function automatic logic is_legal_op(input logic [2:0] code);
    return code <= 3'(op_sqrt);
  endfunction

endpackage

// File: rtl/fpu_bus_if_if.sv
// CPU register bus between a bus master and the FPU register front end.
interface fpu_bus_if_if;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       irq;

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, irq
  );

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, irq
  );
endinterface

// File: rtl/fpu_bus_if.sv
// Byte-wide register front end for the FPU: operand/result registers, command
// launch, completion capture with timeout, sticky status flags and interrupt.
module fpu_bus_if
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst_n,
  fpu_bus_if_if.slave bus,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output e_fpu_op     fpu_op,
  output logic        fpu_start,
  input  logic [31:0] fpu_result,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  localparam logic [15:0] TMO_LAST = FPU_TIMEOUT_CYCLES - 16'd1;

  e_bus_state  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] a_q, b_q, res_q;
  e_fpu_op     op_q;
  logic        done_q, ovr_q, tmo_q, ill_q, irq_en_q;

  logic        in_idle;
  logic        launch, capture, tmo_hit, ill_cmd;
  logic        wr_cmd, wr_sts, wr_ien, wr_ab, ovr_hit;
  logic [4:0]  byte_sel;
  logic [7:0]  status;

  assign in_idle  = (state_q == ST_IDLE);
  assign wr_cmd   = bus.bus_we && (bus.bus_addr == ADDR_CMD);
  assign wr_sts   = bus.bus_we && (bus.bus_addr == ADDR_STATUS);
  assign wr_ien   = bus.bus_we && (bus.bus_addr == ADDR_IRQ_EN);
  assign wr_ab    = bus.bus_we && !bus.bus_addr[3] && in_idle;
  assign ovr_hit  = bus.bus_we && !in_idle && (!bus.bus_addr[3] || bus.bus_addr == ADDR_CMD);
  assign byte_sel = {bus.bus_addr[1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    capture = 1'b0;
    tmo_hit = 1'b0;
    ill_cmd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_cmd) begin
          if (is_legal_op(bus.bus_wdata[2:0])) begin
            launch  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            ill_cmd = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Completion takes priority over the timeout on the same edge.
        if (fpu_cmd_end) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (!fpu_cmd_end && !fpu_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= op_add;
    end else begin
      if (wr_ab) begin
        if (!bus.bus_addr[2]) a_q[byte_sel +: 8] <= bus.bus_wdata;
        else                  b_q[byte_sel +: 8] <= bus.bus_wdata;
      end
      if (launch)  op_q  <= e_fpu_op'(bus.bus_wdata[2:0]);
      if (capture) res_q <= fpu_result;
    end
  end

  // Later assignments override the write-one-to-clear, so hardware sets win.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      ill_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_sts) begin
        if (bus.bus_wdata[STS_DONE])    done_q <= 1'b0;
        if (bus.bus_wdata[STS_OVERRUN]) ovr_q  <= 1'b0;
        if (bus.bus_wdata[STS_TIMEOUT]) tmo_q  <= 1'b0;
        if (bus.bus_wdata[STS_ILLEGAL]) ill_q  <= 1'b0;
      end
      if (launch) begin
        done_q <= 1'b0;
        tmo_q  <= 1'b0;
      end
      if (capture) done_q   <= 1'b1;
      if (tmo_hit) tmo_q    <= 1'b1;
      if (ovr_hit) ovr_q    <= 1'b1;
      if (ill_cmd) ill_q    <= 1'b1;
      if (wr_ien)  irq_en_q <= bus.bus_wdata[0];
    end
  end

  always_comb begin
    status              = '0;
    status[STS_RUNNING] = (state_q == ST_RUN);
    status[STS_DONE]    = done_q;
    status[STS_OVERRUN] = ovr_q;
    status[STS_TIMEOUT] = tmo_q;
    status[STS_ILLEGAL] = ill_q;
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (bus.bus_re) begin
      case (bus.bus_addr[3:2])
        ADDR_A0[3:2]:   bus.bus_rdata = a_q[byte_sel +: 8];
        ADDR_B0[3:2]:   bus.bus_rdata = b_q[byte_sel +: 8];
        ADDR_RES0[3:2]: bus.bus_rdata = res_q[byte_sel +: 8];
        default: begin
          case (bus.bus_addr)
            ADDR_STATUS: bus.bus_rdata = status;
            ADDR_IRQ_EN: bus.bus_rdata = {7'b0, irq_en_q};
            ADDR_CMD:    bus.bus_rdata = '0;
            ADDR_RSVD:   bus.bus_rdata = '0;
            default:     bus.bus_rdata = '0;
          endcase
        end
      endcase
    end
  end

  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign fpu_op    = op_q;
  assign fpu_start = (state_q == ST_RUN);
  assign bus.irq   = done_q & irq_en_q;

endmodule

// File: tb/tb_fpu_bus_if.sv
// Bench for fpu_bus_if: a stub FPU, a register-level reference model checked
// every cycle, and directed scenarios with hand-computed expected values.
module tb_fpu_bus_if;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] fpu_a, fpu_b;
  logic [31:0] fpu_result = '0;
  e_fpu_op     fpu_op;
  logic        fpu_start;
  logic        fpu_cmd_end = 1'b0;
  logic        fpu_busy = 1'b0;

  fpu_bus_if_if bus();

  fpu_bus_if dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .bus        (bus),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_start  (fpu_start),
    .fpu_result (fpu_result),
    .fpu_cmd_end(fpu_cmd_end),
    .fpu_busy   (fpu_busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rise   = 0;
  int n_end    = 0;
  bit cmp_on   = 1'b0;
  bit prev_start = 1'b0;
  bit stub_hang  = 1'b0;
  int stub_lat   = 3;
  int stub_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- single-precision helpers for the stub FPU ----------------
  function automatic real sp2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == '0) d = {s[31], 63'b0};
    else               d = {s[31], {3'b0, s[30:23]} + 11'd896, s[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [30:0] em;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    em = {8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && (d[27:0] != '0 || d[29])) em = em + 31'd1;
    return {d[63], em};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (op == 3'd0) return r2sp(sp2r(a) + sp2r(b));
    return {a[15:0], b[15:0]} ^ 32'h5a5a_0000;
  endfunction

  // ---------------- stub FPU ----------------
  always begin
    @(posedge clk);
    #1;
    if (!arst_n) begin
      stub_cnt = 0; fpu_cmd_end = 1'b0; fpu_busy = 1'b0;
    end else if (fpu_cmd_end) begin
      stub_cnt = 0; fpu_cmd_end = 1'b0; fpu_busy = 1'b0;
    end else if (fpu_start) begin
      fpu_busy = 1'b1;
      if (!stub_hang) begin
        stub_cnt++;
        if (stub_cnt == stub_lat) begin
          fpu_result  = fpu_calc(fpu_a, fpu_b, 3'(fpu_op));
          fpu_cmd_end = 1'b1;
          n_end++;
        end
      end
    end else begin
      fpu_busy = 1'b0;
    end
  end

  // ---------------- register-level reference model ----------------
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2;
  logic [7:0] mA[4], mB[4], mR[4];
  bit m_done, m_ovr, m_tmo, m_ill, m_ien;
  int m_phase, m_runs, m_nxt, m_a;
  logic [2:0] m_op;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 4; i++) begin mA[i] = '0; mB[i] = '0; mR[i] = '0; end
      m_done = 0; m_ovr = 0; m_tmo = 0; m_ill = 0; m_ien = 0;
      m_phase = P_IDLE; m_runs = 0; m_op = '0;
    end else begin
      m_nxt = m_phase;
      m_a   = int'(bus.bus_addr);
      if (bus.bus_we) begin
        if (m_a < 8) begin
          if (m_phase != P_IDLE) m_ovr = 1;
          else if (m_a < 4)      mA[m_a] = bus.bus_wdata;
          else                   mB[m_a - 4] = bus.bus_wdata;
        end else if (m_a == 12) begin
          if (m_phase != P_IDLE)            m_ovr = 1;
          else if (bus.bus_wdata[2:0] > 3'd4) m_ill = 1;
          else begin
            m_op = bus.bus_wdata[2:0]; m_done = 0; m_tmo = 0; m_runs = 0; m_nxt = P_RUN;
          end
        end else if (m_a == 13) begin
          if (bus.bus_wdata[1]) m_done = 0;
          if (bus.bus_wdata[2]) m_ovr  = 0;
          if (bus.bus_wdata[3]) m_tmo  = 0;
          if (bus.bus_wdata[4]) m_ill  = 0;
        end else if (m_a == 14) begin
          m_ien = bus.bus_wdata[0];
        end
      end
      if (m_phase == P_RUN) begin
        if (fpu_cmd_end) begin
          for (int i = 0; i < 4; i++) mR[i] = fpu_result[8*i +: 8];
          m_done = 1; m_nxt = P_DRAIN;
        end else begin
          m_runs++;
          if (m_runs == 4096) begin m_tmo = 1; m_nxt = P_DRAIN; end
        end
      end else if (m_phase == P_DRAIN && !fpu_cmd_end && !fpu_busy) begin
        m_nxt = P_IDLE;
      end
      m_phase = m_nxt;
    end
  end

  function automatic logic [7:0] m_rd();
    int a;
    a = int'(bus.bus_addr);
    if (!bus.bus_re) return 8'h00;
    if (a < 4)   return mA[a];
    if (a < 8)   return mB[a - 4];
    if (a < 12)  return mR[a - 8];
    if (a == 13) return {3'b0, m_ill, m_tmo, m_ovr, m_done, m_phase == P_RUN};
    if (a == 14) return {7'b0, m_ien};
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("start",  32'(fpu_start), 32'(m_phase == P_RUN));
      chk("fpu_a",  fpu_a, {mA[3], mA[2], mA[1], mA[0]});
      chk("fpu_b",  fpu_b, {mB[3], mB[2], mB[1], mB[0]});
      chk("fpu_op", 32'(fpu_op), 32'(m_op));
      chk("irq",    32'(bus.irq), 32'(m_done & m_ien));
      chk("rdata",  32'(bus.bus_rdata), 32'(m_rd()));
      if (fpu_start && !prev_start) n_rise++;
      prev_start = fpu_start;
    end
  end

  // ---------------- bus tasks (entered and left at posedge+1) ----------------
  task automatic bw(input logic [3:0] a, input logic [7:0] d);
    bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
    @(posedge clk); #1;
    bus.bus_we = 1'b0;
  endtask

  task automatic br(input logic [3:0] a, output logic [7:0] d);
    bus.bus_re = 1'b1; bus.bus_addr = a;
    #2 d = bus.bus_rdata;
    @(posedge clk); #1;
    bus.bus_re = 1'b0;
  endtask

  task automatic br_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    br(a, d);
    chk(nm, 32'(d), 32'(exp));
  endtask

  task automatic wr32(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) bw(base + 4'(i), v[8*i +: 8]);
  endtask

  task automatic wait_quiet(input int maxc, input string nm);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (!fpu_start && !fpu_busy && !fpu_cmd_end) break;
    end
    chk(nm, 32'(i < maxc), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int r0, e0, hc, i;
    bus.bus_addr = '0; bus.bus_wdata = '0; bus.bus_we = 1'b0; bus.bus_re = 1'b0;
    cmp_on = 1'b1;

    // Reset state
    #13;
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_irq",   32'(bus.irq), 32'd0);
    chk("rst_a",     fpu_a, 32'd0);
    chk("rst_op",    32'(fpu_op), 32'(op_add));
    @(posedge clk); #2 arst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) br_chk("rst_rd", 4'(a), 8'h00);

    // 1.0 + 1.1 through the stub adder
    wr32(4'h0, 32'h3f80_0000);
    wr32(4'h4, 32'h3f8c_cccd);
    bw(4'hE, 8'h01);
    bw(4'hC, 8'h00);
    wait_quiet(50, "add_wait");
    br_chk("add_r0", 4'h8, 8'h66);
    br_chk("add_r1", 4'h9, 8'h66);
    br_chk("add_r2", 4'hA, 8'h06);
    br_chk("add_r3", 4'hB, 8'h40);
    chk("add_irq", 32'(bus.irq), 32'd1);
    br_chk("add_sts", 4'hD, 8'h02);
    br_chk("ien_rd", 4'hE, 8'h01);

    // Undefined op code
    r0 = n_rise;
    bw(4'hC, 8'h07);
    repeat (5) begin @(posedge clk); #1; end
    chk("ill_norise", 32'(n_rise - r0), 32'd0);
    br_chk("ill_sts", 4'hD, 8'h12);
    bw(4'hD, 8'h1f);
    br_chk("clr_sts", 4'hD, 8'h00);

    // Overrun writes during RUN
    stub_lat = 10;
    r0 = n_rise; e0 = n_end;
    bw(4'hC, 8'h02);
    bw(4'h4, 8'haa);
    bw(4'hC, 8'h01);
    chk("ovr_b",  fpu_b, 32'h3f8c_cccd);
    chk("ovr_op", 32'(fpu_op), 32'(op_mul));
    wait_quiet(60, "ovr_wait");
    chk("ovr_rise", 32'(n_rise - r0), 32'd1);
    chk("ovr_ends", 32'(n_end - e0), 32'd1);
    br_chk("ovr_sts", 4'hD, 8'h06);
    br_chk("ovr_r0", 4'h8, 8'hcd);
    br_chk("ovr_r3", 4'hB, 8'h5a);

    // Status clear of done on the capture edge
    bw(4'hD, 8'h1f);
    stub_lat = 3;
    bw(4'hC, 8'h00);
    for (i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (fpu_cmd_end) break;
    end
    chk("race_seen", 32'(i < 20), 32'd1);
    bus.bus_we = 1'b1; bus.bus_addr = 4'hD; bus.bus_wdata = 8'h02;
    @(posedge clk); #1;
    bus.bus_we = 1'b0;
    wait_quiet(20, "race_wait");
    br_chk("race_sts", 4'hD, 8'h02);

    // Timeout with a hung FPU
    stub_hang = 1'b1;
    bw(4'hC, 8'h00);
    hc = 0;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fpu_start) hc++;
      else break;
    end
    chk("tmo_cycles", 32'(hc), 32'd4096);
    @(posedge clk); #1;
    wait_quiet(20, "tmo_wait");
    br_chk("tmo_sts", 4'hD, 8'h08);
    br_chk("tmo_r0", 4'h8, 8'h66);
    br_chk("tmo_r2", 4'hA, 8'h06);
    br_chk("tmo_r3", 4'hB, 8'h40);

    // Asynchronous reset mid-RUN, then a normal command
    bw(4'hC, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_run", 32'(fpu_start), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_start", 32'(fpu_start), 32'd0);
    chk("arst_irq",   32'(bus.irq), 32'd0);
    @(posedge clk); #2;
    arst_n = 1'b1;
    stub_hang = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) br_chk("arst_rd", 4'(a), 8'h00);
    chk("arst_op", 32'(fpu_op), 32'(op_add));
    wr32(4'h0, 32'h4000_0000);
    wr32(4'h4, 32'h3f00_0000);
    bw(4'hE, 8'h01);
    bw(4'hC, 8'h00);
    wait_quiet(50, "post_wait");
    br_chk("post_r0", 4'h8, 8'h00);
    br_chk("post_r2", 4'hA, 8'h20);
    br_chk("post_r3", 4'hB, 8'h40);
    chk("post_irq", 32'(bus.irq), 32'd1);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
